// File: rtl/ps2_tx_if.sv
// Host-side and pin-side signal bundle for the PS/2 host-to-device transmitter.
//
// Handshake: start is a request that is taken only while the transmitter is
// idle (busy, done and err all low); a request at any other time is dropped,
// never queued. data must be valid on the cycle start is taken. Completion is
// a one-cycle pulse on done (ACK seen) or err (err_code says why); busy is
// high from the cycle after acceptance until that pulse.
interface ps2_tx_if;
    logic [7:0] data;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [2:0] state_dbg;

    modport master (
        output data, start, ps2_clk_in, ps2_data_in,
        input  busy, done, err, err_code, ps2_clk_oe, ps2_data_oe, state_dbg
    );

    modport slave (
        input  data, start, ps2_clk_in, ps2_data_in,
        output busy, done, err, err_code, ps2_clk_oe, ps2_data_oe, state_dbg
    );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shift out one byte on
// device clock falls, check ACK, wait for the bus to go idle.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    ps2_tx_if.slave  bus
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
    } state_t;

    state_t         state, state_d;
    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           clk_filt;
    logic [FW-1:0]  flt_cnt;
    logic           fall;
    logic [IW-1:0]  inh_cnt;
    logic [WW-1:0]  wd_cnt;
    logic [3:0]     bit_cnt;
    logic [8:0]     shreg;
    logic           tx_oe;
    logic [1:0]     err_code;
    logic           accept;
    logic           timeout;
    logic           inh_last;
    logic           watch;
    logic [1:0]     fail_code;

    // Two-flop synchronizers; lines idle high so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= bus.ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= bus.ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: accept a clock level change after FILTER_LEN equal samples; pulse fall on 1->0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic; fail_code records why a FAIL transition happens.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        fail_code = 2'd1;
        timeout   = (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) && !fall;
        inh_last  = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
        watch     = (state == S_REQ) || (state == S_SEND) ||
                    (state == S_ACK) || (state == S_WAIT_IDLE);
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_last) state_d = S_REQ;
            end
            S_REQ: begin
                if (timeout) state_d = S_FAIL;
                else         state_d = S_SEND;
            end
            S_SEND: begin
                if (timeout)                       state_d = S_FAIL;
                else if (fall && bit_cnt == 4'd9)  state_d = S_ACK;
            end
            S_ACK: begin
                if (timeout) begin
                    state_d = S_FAIL;
                end else if (fall) begin
                    if (data_s2) begin
                        fail_code = 2'd2;
                        state_d   = S_FAIL;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (timeout) begin
                    fail_code = 2'd3;
                    state_d   = S_FAIL;
                end else if (clk_s2 && data_s2) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: inhibit timer, watchdog, bit shifter and error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inh_cnt  <= '0;
            wd_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_oe    <= 1'b0;
            err_code <= 2'd0;
        end else begin
            if (accept) begin
                shreg    <= {~^bus.data, bus.data};
                err_code <= 2'd0;
                bit_cnt  <= '0;
                inh_cnt  <= '0;
                tx_oe    <= 1'b1;
            end else if (state == S_INHIBIT) begin
                inh_cnt <= inh_cnt + 1'b1;
            end

            if (watch) wd_cnt <= fall ? '0 : wd_cnt + 1'b1;
            else       wd_cnt <= '0;

            if (state == S_SEND && fall) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt < 4'd9) begin
                    tx_oe <= ~shreg[0];
                    shreg <= shreg >> 1;
                end else begin
                    tx_oe <= 1'b0;
                end
            end

            if (state_d == S_FAIL) err_code <= fail_code;
        end
    end

    assign bus.ps2_clk_oe  = (state == S_INHIBIT);
    assign bus.ps2_data_oe = ((state == S_INHIBIT) && inh_last) ||
                             (state == S_REQ) ||
                             ((state == S_SEND) && tx_oe);
    assign bus.busy        = (state == S_INHIBIT) || (state == S_REQ) ||
                             (state == S_SEND) || (state == S_ACK) ||
                             (state == S_WAIT_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.err         = (state == S_FAIL);
    assign bus.err_code    = err_code;
    assign bus.state_dbg   = state;

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Shares the kbd[0] clock line and kbd[1] data line with the existing PS/2 receiver, and runs on the fast system clock.
- Drives the lines open-drain through drive-low enables, follows the standard request-to-send sequence, shifts out the frame on device-generated clock edges, and checks the device ACK.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks that ps2 clock is held low during the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750_000: maximum system clocks allowed between consecutive device falling edges, or before the first one (15 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples needed before a ps2 clock level change is accepted.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- data, in, 8: byte to send; sampled on the cycle start is accepted.
- start, in, 1: transmit request; accepted only in IDLE.
- ps2_clk_in, in, 1: ps2 clock pin level.
- ps2_data_in, in, 1: ps2 data pin level.
- ps2_clk_oe, out, 1: 1 = drive ps2 clock low; 0 = release (pull-up).
- ps2_data_oe, out, 1: 1 = drive ps2 data low; 0 = release.
- busy, out, 1: high from the cycle after start is accepted until the cycle done or err pulses.
- done, out, 1: one-cycle pulse; frame sent and ACK received.
- err, out, 1: one-cycle pulse; timeout or missing ACK.
- err_code, out, 2: 0 none, 1 first-edge or bit timeout, 2 no ACK, 3 bus not idle at end. Holds until the next start is accepted.

Behaviour:
- Reset (async, immediate): both oe = 0, busy = 0, done = 0, err = 0, err_code = 0, state IDLE. A reset mid-frame releases both lines in the same instant.
- Input conditioning: 2-FF synchronizer on both pins. The ps2 clock passes through the FILTER_LEN glitch filter. A falling edge is a filtered 1->0 transition, producing a one-cycle pulse fall, 2+FILTER_LEN cycles after the pin edge.
- Frame format: start bit 0, data[0]..data[7] LSB first, odd parity (parity = ~^data), stop bit 1 (data released), then device ACK (data low).
- IDLE: oe = 0. On start, latch data into a shift register, compute and latch parity, set busy, go to INHIBIT.
- INHIBIT: clk_oe = 1 for exactly INHIBIT_CYCLES cycles. data_oe goes to 1 in the last cycle of INHIBIT. Go to REQ.
- REQ: clk_oe = 0 and data_oe = 1 (start bit). Watchdog loaded with TIMEOUT_CYCLES. Go to SEND.
- SEND: edge counter n = 1..10, counting falls.
  - On fall n = 1..8, data_oe = ~data[n-1].
  - On fall 9, data_oe = ~parity.
  - On fall 10, data_oe = 0 (stop bit).
  - The new value appears the cycle after the fall pulse. Watchdog reloads on every fall.
  - After fall 10, go to ACK.
- ACK: on fall 11, sample synchronized data. If 0, go to WAIT_IDLE; if 1, set err_code = 2 and go to FAIL.
- WAIT_IDLE: wait for synchronized clock = 1 and data = 1 together. Then pulse done for one cycle, clear busy, go to IDLE.
- Watchdog: any state from REQ to WAIT_IDLE whose watchdog expires goes to FAIL.
  - err_code = 1 when the expiry is in REQ, SEND or ACK.
  - err_code = 3 when the expiry is in WAIT_IDLE.
- FAIL: one cycle with both oe = 0, err = 1, busy cleared; then IDLE.
- start while busy: ignored, not queued.
- start on the same cycle as the done or err pulse: ignored. Accepted only once in IDLE.
- Device edges while IDLE: ignored. The device is the master then and the receiver owns the line.
- Protocol timing: all host data changes happen after device falls; the device samples on rising edges.

Test Plan:
- Send 0xED with INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 2000, FILTER_LEN = 2, and a BFM device clocking at 200-cycle half periods and ACKing -> clk_oe high exactly 20 cycles; bits observed at device rising edges are 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err_code = 0.
- Send 0x00 -> parity bit 1. Send 0x01 -> parity bit 0. Data bits all match; done each time.
- Device never clocks after REQ -> err pulse 2000 cycles after REQ entry; err_code = 1; both oe = 0; busy = 0.
- Device omits ACK (data high at fall 11) -> err_code = 2, err pulse, no done.
- Device stops clocking after fall 5 -> timeout, err_code = 1, lines released. The next start then succeeds with 0xFF.
- Assert rst_n low during SEND bit 4 -> oe = 0 asynchronously, busy = 0; no done or err pulse. start pulses while busy are ignored (single frame seen). A 1-cycle glitch on the ps2 clock is not counted as an edge.
